// File: rtl/telemetry_frame_tx.sv
// rtl/telemetry_frame_tx.sv - periodic ASCII hex telemetry framer driving a UART transmitter
// Optional feature macro: TELEM_CHECKSUM_EN (appends "*HH" XOR checksum before CR LF)
module telemetry_frame_tx #(
  parameter int         NUM_CH        = 4,
  parameter int         CH_WIDTH      = 16,
  parameter int         PERIOD_CYCLES = 10000,
  parameter logic [7:0] SEP_CHAR      = 8'h20
) (
  input  logic                       CLK_10MHZ,
  input  logic                       rst_n,
  input  logic [NUM_CH*CH_WIDTH-1:0] ch_data,
  input  logic [NUM_CH-1:0]          ch_valid,
  input  logic                       trig_ext,
  input  logic                       tx_busy,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  output logic                       frame_active,
  output logic [15:0]                frame_cnt,
  output logic [7:0]                 overrun_cnt
);

  localparam int ND    = (CH_WIDTH + 3) / 4;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DIG_W = (ND > 1) ? $clog2(ND) : 1;
  localparam int TMR_W = $clog2(PERIOD_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_SEND,
    S_HOLD,
    S_DONE
  } state_t;

  // Which part of the frame the next FETCH produces
  typedef enum logic [2:0] {
    SEG_DIG,
    SEG_SEP,
    SEG_STAR,
    SEG_CK_HI,
    SEG_CK_LO,
    SEG_CR,
    SEG_LF
  } seg_t;

  state_t                     state_q, state_d;
  seg_t                       seg_q, seg_d;
  logic [TMR_W-1:0]           timer_q, timer_d;
  logic [CH_W-1:0]            ch_idx_q, ch_idx_d;
  logic [DIG_W-1:0]           dig_idx_q, dig_idx_d;
  logic [NUM_CH*CH_WIDTH-1:0] snap_data_q, snap_data_d;
  logic [NUM_CH-1:0]          snap_valid_q, snap_valid_d;
  logic [7:0]                 byte_q, byte_d;
  logic                       last_q, last_d;
  logic                       tx_start_q, tx_start_d;
  logic [7:0]                 tx_data_q, tx_data_d;
  logic                       frame_active_q, frame_active_d;
  logic [15:0]                frame_cnt_q, frame_cnt_d;
  logic [7:0]                 overrun_cnt_q, overrun_cnt_d;
`ifdef TELEM_CHECKSUM_EN
  logic [7:0]                 xor_q, xor_d;
`endif

  logic                timer_tc;
  logic                trig;
  logic [CH_WIDTH-1:0] cur_word;
  logic [ND*4-1:0]     cur_word_ext;
  logic [3:0]          cur_nib;
  logic                cur_valid;
  logic [7:0]          payload_byte;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    return 8'h37 + {4'h0, nib};
  endfunction

  assign timer_tc = (timer_q == TMR_W'(PERIOD_CYCLES - 1));
  assign trig     = timer_tc | trig_ext;

  // Select the current digit from the snapshot; short top nibble is zero-extended
  always_comb begin
    cur_word     = snap_data_q[int'(ch_idx_q)*CH_WIDTH +: CH_WIDTH];
    cur_word_ext = (ND*4)'(cur_word);
    cur_nib      = cur_word_ext[int'(dig_idx_q)*4 +: 4];
    cur_valid    = snap_valid_q[ch_idx_q];
    payload_byte = cur_valid ? hex_char(cur_nib) : 8'h78;
  end

  // Next-state logic for the trigger timer, frame sequencer and counters
  always_comb begin
    state_d        = state_q;
    seg_d          = seg_q;
    ch_idx_d       = ch_idx_q;
    dig_idx_d      = dig_idx_q;
    snap_data_d    = snap_data_q;
    snap_valid_d   = snap_valid_q;
    byte_d         = byte_q;
    last_d         = last_q;
    tx_start_d     = 1'b0;
    tx_data_d      = tx_data_q;
    frame_active_d = frame_active_q;
    frame_cnt_d    = frame_cnt_q;
    overrun_cnt_d  = overrun_cnt_q;
`ifdef TELEM_CHECKSUM_EN
    xor_d          = xor_q;
`endif

    timer_d = timer_tc ? '0 : timer_q + TMR_W'(1);

    if (trig && (state_q != S_IDLE) && (overrun_cnt_q != 8'hFF)) begin
      overrun_cnt_d = overrun_cnt_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (trig) begin
          frame_active_d = 1'b1;
          state_d        = S_LOAD;
        end
      end
      S_LOAD: begin
        snap_data_d  = ch_data;
        snap_valid_d = ch_valid;
        ch_idx_d     = '0;
        dig_idx_d    = DIG_W'(ND - 1);
        seg_d        = SEG_DIG;
        last_d       = 1'b0;
`ifdef TELEM_CHECKSUM_EN
        xor_d        = 8'h00;
`endif
        state_d      = S_FETCH;
      end
      S_FETCH: begin
        case (seg_q)
          SEG_DIG: begin
            byte_d = payload_byte;
`ifdef TELEM_CHECKSUM_EN
            xor_d  = xor_q ^ payload_byte;
`endif
            if (dig_idx_q == '0) begin
              if (ch_idx_q == CH_W'(NUM_CH - 1)) begin
`ifdef TELEM_CHECKSUM_EN
                seg_d = SEG_STAR;
`else
                seg_d = SEG_CR;
`endif
              end else begin
                seg_d = SEG_SEP;
              end
            end else begin
              dig_idx_d = dig_idx_q - DIG_W'(1);
            end
          end
          SEG_SEP: begin
            byte_d    = SEP_CHAR;
`ifdef TELEM_CHECKSUM_EN
            xor_d     = xor_q ^ SEP_CHAR;
`endif
            ch_idx_d  = ch_idx_q + CH_W'(1);
            dig_idx_d = DIG_W'(ND - 1);
            seg_d     = SEG_DIG;
          end
`ifdef TELEM_CHECKSUM_EN
          SEG_STAR: begin
            byte_d = 8'h2A;
            seg_d  = SEG_CK_HI;
          end
          SEG_CK_HI: begin
            byte_d = hex_char(xor_q[7:4]);
            seg_d  = SEG_CK_LO;
          end
          SEG_CK_LO: begin
            byte_d = hex_char(xor_q[3:0]);
            seg_d  = SEG_CR;
          end
`endif
          SEG_CR: begin
            byte_d = 8'h0D;
            seg_d  = SEG_LF;
          end
          SEG_LF: begin
            byte_d = 8'h0A;
            last_d = 1'b1;
          end
          default: begin
            byte_d = 8'h0D;
            seg_d  = SEG_LF;
          end
        endcase
        state_d = S_SEND;
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = byte_q;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        // Transmitter raises busy only after seeing start, so skip one cycle
        state_d = last_q ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        frame_active_d = 1'b0;
        frame_cnt_d    = frame_cnt_q + 16'd1;
        state_d        = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Register all state; reset aborts any frame in flight
  always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      seg_q          <= SEG_DIG;
      timer_q        <= '0;
      ch_idx_q       <= '0;
      dig_idx_q      <= '0;
      snap_data_q    <= '0;
      snap_valid_q   <= '0;
      byte_q         <= 8'h00;
      last_q         <= 1'b0;
      tx_start_q     <= 1'b0;
      tx_data_q      <= 8'h00;
      frame_active_q <= 1'b0;
      frame_cnt_q    <= 16'h0000;
      overrun_cnt_q  <= 8'h00;
`ifdef TELEM_CHECKSUM_EN
      xor_q          <= 8'h00;
`endif
    end else begin
      state_q        <= state_d;
      seg_q          <= seg_d;
      timer_q        <= timer_d;
      ch_idx_q       <= ch_idx_d;
      dig_idx_q      <= dig_idx_d;
      snap_data_q    <= snap_data_d;
      snap_valid_q   <= snap_valid_d;
      byte_q         <= byte_d;
      last_q         <= last_d;
      tx_start_q     <= tx_start_d;
      tx_data_q      <= tx_data_d;
      frame_active_q <= frame_active_d;
      frame_cnt_q    <= frame_cnt_d;
      overrun_cnt_q  <= overrun_cnt_d;
`ifdef TELEM_CHECKSUM_EN
      xor_q          <= xor_d;
`endif
    end
  end

  assign tx_start     = tx_start_q;
  assign tx_data      = tx_data_q;
  assign frame_active = frame_active_q;
  assign frame_cnt    = frame_cnt_q;
  assign overrun_cnt  = overrun_cnt_q;

endmodule

// File: tb/tb_telemetry_frame_tx.sv
// tb/tb_telemetry_frame_tx.sv - scoreboard bench for telemetry_frame_tx
module tb_telemetry_frame_tx;

  localparam int NCH = 3;
  localparam int CW  = 10;
  localparam int ND  = 3;
  localparam int P   = 2000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH*CW-1:0] ch_data;
  logic [NCH-1:0]    ch_valid;
  logic              trig_ext;
  logic              busy_m;
  logic              hold_busy;
  logic              tx_busy;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              frame_active;
  logic [15:0]       frame_cnt;
  logic [7:0]        overrun_cnt;

  logic [7:0] exp_q[$];
  int n_pass = 0;
  int n_total = 0;
  int bytes_seen = 0;
  int first_start_cyc = -1;
  int cyc = 0;
  int exp_frames;
  int exp_overrun;

  assign tx_busy = busy_m | hold_busy;

  always #50 clk = ~clk;

  telemetry_frame_tx #(
    .NUM_CH(NCH),
    .CH_WIDTH(CW),
    .PERIOD_CYCLES(P),
    .SEP_CHAR(8'h20)
  ) dut (
    .CLK_10MHZ(clk),
    .rst_n(rst_n),
    .ch_data(ch_data),
    .ch_valid(ch_valid),
    .trig_ext(trig_ext),
    .tx_busy(tx_busy),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .frame_active(frame_active),
    .frame_cnt(frame_cnt),
    .overrun_cnt(overrun_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] hex_ascii(input int n);
    if (n < 10) return 8'(48 + n);
    return 8'(65 + n - 10);
  endfunction

  // Reference model: a whole frame as a byte list, channel 0 first
  task automatic push_frame(input logic [NCH*CW-1:0] data, input logic [NCH-1:0] valid);
    int word;
    logic [7:0] c;
    logic [7:0] sum;
    sum = 8'h00;
    for (int ch = 0; ch < NCH; ch++) begin
      word = int'(data >> (ch * CW)) & ((1 << CW) - 1);
      for (int d = ND - 1; d >= 0; d--) begin
        c = valid[ch] ? hex_ascii((word >> (4 * d)) & 15) : 8'h78;
        exp_q.push_back(c);
        sum = sum ^ c;
      end
      if (ch != NCH - 1) begin
        exp_q.push_back(8'h20);
        sum = sum ^ 8'h20;
      end
    end
`ifdef TELEM_CHECKSUM_EN
    exp_q.push_back(8'h2A);
    exp_q.push_back(hex_ascii(int'(sum[7:4])));
    exp_q.push_back(hex_ascii(int'(sum[3:0])));
`endif
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Known-answer frame for ch = {0x000, 0x3FF, 0x1A3}, all valid
  task automatic push_literal();
    string s;
`ifdef TELEM_CHECKSUM_EN
    s = "1A3 3FF 000*40\r\n";
`else
    s = "1A3 3FF 000\r\n";
`endif
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // Cycle count since reset release, aligned with the DUT timer value
  initial begin
    forever begin
      @(posedge clk);
      cyc = (rst_n === 1'b1) ? cyc + 1 : 0;
    end
  end

  // Transmitter model: busy rises right after start, lasts a random few cycles
  initial begin
    busy_m = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        busy_m = 1'b1;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        busy_m = 1'b0;
      end
    end
  end

  // Monitor: every launched byte is popped from the scoreboard and compared
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_start === 1'b1) begin
        bytes_seen++;
        if (first_start_cyc < 0) first_start_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_byte: got 0x%0h expected no byte", tx_data);
        end else begin
          check("tx_data", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tx_start"}, {31'h0, tx_start}, 32'h0);
    check({tag, "_tx_data"}, {24'h0, tx_data}, 32'h0);
    check({tag, "_frame_active"}, {31'h0, frame_active}, 32'h0);
    check({tag, "_frame_cnt"}, {16'h0, frame_cnt}, 32'h0);
    check({tag, "_overrun_cnt"}, {24'h0, overrun_cnt}, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #10;
    rst_n     = 1'b0;
    trig_ext  = 1'b0;
    hold_busy = 1'b0;
    #1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #10;
    rst_n = 1'b1;
    bytes_seen      = 0;
    first_start_cyc = -1;
    exp_frames      = 0;
    exp_overrun     = 0;
  endtask

  task automatic pulse_trig();
    @(negedge clk);
    trig_ext = 1'b1;
    @(negedge clk);
    trig_ext = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || frame_active !== 1'b0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_in_time"}, {31'h0, (n < 3000)}, 32'h1);
    check({tag, "_pending_bytes"}, exp_q.size(), 32'h0);
  endtask

  task automatic wait_bytes(input int k);
    int n;
    n = 0;
    while (bytes_seen < k && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("bytes_reached_in_time", {31'h0, (n < 2000)}, 32'h1);
  endtask

  initial begin
    logic [NCH*CW-1:0] d;
    logic [NCH-1:0]    v;
    int                seen_hold;

    rst_n     = 1'b0;
    ch_data   = '0;
    ch_valid  = '0;
    trig_ext  = 1'b0;
    hold_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");

    // Directed and random frames, with mid-frame data changes and extra triggers
    do_reset();
    for (int it = 0; it < 6; it++) begin
      if (it == 0) begin
        d = {10'h000, 10'h3FF, 10'h1A3};
        v = 3'b111;
        push_literal();
      end else begin
        d = 30'($urandom);
        v = (it == 1) ? 3'b101 : 3'($urandom_range(0, 7));
        push_frame(d, v);
      end
      ch_data  = d;
      ch_valid = v;
      pulse_trig();
      repeat (4) @(negedge clk);
      ch_data  = ~d;
      ch_valid = ~v;
      if (it % 2 == 1) begin
        pulse_trig();
        exp_overrun++;
      end
      wait_done("frame");
      exp_frames++;
      check("frame_cnt", {16'h0, frame_cnt}, exp_frames);
      check("overrun_cnt", {24'h0, overrun_cnt}, exp_overrun);
    end

    // Transmitter stuck busy: frame stalls, triggers count as overruns and saturate
    do_reset();
    d = 30'($urandom);
    v = 3'b111;
    ch_data  = d;
    ch_valid = v;
    push_frame(d, v);
    pulse_trig();
    wait_bytes(1);
    hold_busy = 1'b1;
    @(negedge clk);
    seen_hold = bytes_seen;
    repeat (3) pulse_trig();
    check("overrun_after_3", {24'h0, overrun_cnt}, 32'd3);
    check("active_while_stuck", {31'h0, frame_active}, 32'h1);
    repeat (257) pulse_trig();
    check("overrun_saturated", {24'h0, overrun_cnt}, 32'd255);
    check("no_bytes_while_stuck", bytes_seen, seen_hold);
    hold_busy = 1'b0;
    wait_done("stuck");
    check("frame_cnt_after_stuck", {16'h0, frame_cnt}, 32'd1);
    check("overrun_kept", {24'h0, overrun_cnt}, 32'd255);

    // Reset in the middle of a frame, then a clean restart from byte 0
    do_reset();
    d = 30'($urandom);
    v = 3'($urandom_range(0, 7));
    ch_data  = d;
    ch_valid = v;
    push_frame(d, v);
    pulse_trig();
    wait_bytes(4);
    @(posedge clk);
    #10;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midframe_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #10;
    rst_n = 1'b1;
    bytes_seen = 0;
    repeat (30) @(negedge clk);
    check("no_bytes_after_reset", bytes_seen, 32'h0);
    push_frame(d, v);
    pulse_trig();
    wait_done("restart");
    check("frame_cnt_restart", {16'h0, frame_cnt}, 32'd1);

    // Internal timer trigger, then timer and external trigger in the same cycle
    do_reset();
    d = 30'($urandom);
    v = 3'($urandom_range(0, 7));
    ch_data  = d;
    ch_valid = v;
    push_frame(d, v);
    while (cyc < P + 20) @(negedge clk);
    check("timer_first_start_window",
          {31'h0, (first_start_cyc >= P + 1 && first_start_cyc <= P + 5)}, 32'h1);
    wait_done("timer");
    check("timer_frame_cnt", {16'h0, frame_cnt}, 32'd1);
    check("timer_overrun", {24'h0, overrun_cnt}, 32'd0);
    d = 30'($urandom);
    v = 3'($urandom_range(0, 7));
    ch_data  = d;
    ch_valid = v;
    push_frame(d, v);
    while (cyc < 2 * P - 1) @(negedge clk);
    trig_ext = 1'b1;
    @(negedge clk);
    trig_ext = 1'b0;
    wait_done("simultaneous");
    check("simultaneous_frame_cnt", {16'h0, frame_cnt}, 32'd2);
    check("simultaneous_overrun", {24'h0, overrun_cnt}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
